// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller: owns the PC, runs a single-outstanding
// req/addr_ok/data_ok fetch and presents a registered packet to decode.
//
// state  | meaning
// IDLE   | just out of reset, no request yet
// REQ    | request presented at pc (or misaligned pc being turned into an error packet)
// WAIT   | request accepted, waiting for read data
// OUT    | packet valid toward decode, held while stalled
module fetch_ctrl #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = 32'hBFC0_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              jump,
    input  logic [ADDR_W-1:0] pc_jump,
    input  logic              jump_reg,
    input  logic [ADDR_W-1:0] pc_jump_reg,
    input  logic              branch,
    input  logic [ADDR_W-1:0] pc_branch,
    input  logic              exc,
    input  logic [ADDR_W-1:0] pc_exc,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [31:0]       inst_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4,
    output logic [31:0]       if_inst,
    output logic              if_adel
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pending_pc_q, pending_pc_d;
    logic              pending_q, pending_d;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              capture;
    logic              capture_adel;

    logic [ADDR_W-1:0] if_pc_q, if_pc_plus4_q;
    logic [31:0]       if_inst_q;
    logic              if_adel_q;

    assign redirect = exc | branch | jump_reg | jump;
    assign pc_plus4 = pc_q + ADDR_W'(4);

    always_comb begin
        redirect_pc = pc_jump;
        if (exc)
            redirect_pc = pc_exc;
        else if (branch)
            redirect_pc = pc_branch;
        else if (jump_reg)
            redirect_pc = pc_jump_reg;
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_d    = pending_q;
        pending_pc_d = pending_pc_q;
        capture      = 1'b0;
        capture_adel = 1'b0;
        inst_req     = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                if (pc_q[1:0] != 2'b00) begin
                    // A redirect supersedes the error packet for this pc.
                    if (redirect) begin
                        pc_d      = redirect_pc;
                        pending_d = 1'b0;
                    end else if (pending_q) begin
                        pc_d      = pending_pc_q;
                        pending_d = 1'b0;
                    end else begin
                        capture      = 1'b1;
                        capture_adel = 1'b1;
                        state_d      = S_OUT;
                    end
                end else begin
                    inst_req = 1'b1;
                    if (redirect) begin
                        pending_d    = 1'b1;
                        pending_pc_d = redirect_pc;
                    end
                    if (inst_addr_ok)
                        state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (inst_data_ok) begin
                    if (redirect) begin
                        pc_d      = redirect_pc;
                        pending_d = 1'b0;
                        state_d   = S_REQ;
                    end else if (pending_q) begin
                        pc_d      = pending_pc_q;
                        pending_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        capture = 1'b1;
                        state_d = S_OUT;
                    end
                end else if (redirect) begin
                    pending_d    = 1'b1;
                    pending_pc_d = redirect_pc;
                end
            end

            S_OUT: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (!stall) begin
                    pc_d    = pc_plus4;
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            pending_q    <= 1'b0;
            pending_pc_q <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_pc_q       <= RESET_PC;
            if_pc_plus4_q <= RESET_PC + ADDR_W'(4);
            if_inst_q     <= 32'h0;
            if_adel_q     <= 1'b0;
        end else if (capture) begin
            if_pc_q       <= pc_q;
            if_pc_plus4_q <= pc_plus4;
            if_inst_q     <= capture_adel ? 32'h0 : inst_rdata;
            if_adel_q     <= capture_adel;
        end
    end

    assign inst_addr   = pc_q;
    assign if_valid    = (state_q == S_OUT);
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign if_inst     = if_inst_q;
    assign if_adel     = if_adel_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and selects the next PC from sequential, jump, jump-register, branch and exception redirects.
- Drives a request/address-ok/data-ok instruction-memory handshake with one fetch outstanding.
- Presents a registered fetch packet (pc, pc+4, instruction, address-error flag) to decode, honouring the decode stall.

Parameters:
RESET_PC, 32'hBFC0_0000, PC loaded on reset
ADDR_W, 32, PC/address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  decode not accepting the fetch packet this cycle
jump  in  1  J/JAL redirect request
pc_jump  in  ADDR_W  jump target
jump_reg  in  1  JR/JALR redirect request
pc_jump_reg  in  ADDR_W  register target
branch  in  1  taken-branch redirect request
pc_branch  in  ADDR_W  branch target
exc  in  1  exception redirect request
pc_exc  in  ADDR_W  exception vector
inst_req  out  1  memory request valid
inst_addr  out  ADDR_W  memory request address
inst_addr_ok  in  1  request accepted this cycle
inst_data_ok  in  1  read data valid this cycle
inst_rdata  in  32  read data
if_valid  out  1  fetch packet valid
if_pc  out  ADDR_W  PC of packet
if_pc_plus4  out  ADDR_W  if_pc + 4
if_inst  out  32  instruction word
if_adel  out  1  packet carries an address-error (misaligned PC)

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_PC, state=IDLE, pending=0, inst_req=0, if_valid=0, if_adel=0, if_inst=0, if_pc=RESET_PC, if_pc_plus4=RESET_PC+4.
- Redirect priority: exc > branch > jump_reg > jump. Redirect target = target of highest-priority active request. A redirect is any of the four asserted.
- Sequential next PC = pc + 4, modulo 2^ADDR_W (wraps 32'hFFFF_FFFC -> 0).
- States:
  - IDLE: entered only from reset; next cycle -> REQ.
  - REQ: if pc[1:0]!=0, no request; load the packet with if_pc=pc, if_inst=0, if_adel=1 and go to OUT. Otherwise inst_req=1 and inst_addr=pc. On inst_addr_ok -> WAIT.
  - WAIT: inst_req=0. On inst_data_ok, either discard the data (see Redirect handling) or capture the packet, where if_pc=pc, if_pc_plus4=pc+4, if_inst=inst_rdata, if_adel=0, and go to OUT.
  - OUT: if_valid=1. If stall=0, the packet is consumed: pc <= pc+4, go to REQ. If stall=1, hold all if_* outputs stable.
- Redirect handling:
  - REQ before inst_addr_ok: inst_addr stays stable while inst_req=1. The redirect is latched into pending/pending_pc.
  - REQ, redirect in the same cycle as inst_addr_ok: latch pending and go to WAIT.
  - WAIT: latch pending/pending_pc. This includes a redirect in the same cycle as inst_data_ok, in which case the returned data is discarded.
  - WAIT, inst_data_ok with pending=1: discard the data, pc <= pending_pc, pending <= 0, go to REQ. No packet is produced.
  - OUT: pc <= redirect target, drop the packet (if_valid=0 next cycle), go to REQ. This applies regardless of stall.
  - A later redirect overwrites pending_pc; the newest redirect wins.
  - REQ with a misaligned pc and pending=1: skip the error packet, pc <= pending_pc, stay in REQ.
- Latency:
  - First inst_req rises 2 cycles after reset deasserts (IDLE, then REQ).
  - With addr_ok and data_ok each one cycle after the prior event, the packet is valid 3 cycles after inst_req rises.
  - Sustained throughput is 1 instruction per 3 cycles (single outstanding request).
- if_valid is registered. if_* outputs are only updated on capture.
- Reset mid-operation returns to IDLE and drops any outstanding request. The memory must also be reset, since a late inst_data_ok is ignored in IDLE/REQ.
- inst_data_ok outside WAIT is ignored.

Test Plan:
- Reset release, memory with addr_ok and data_ok immediate -> inst_req rises at cycle 2 with inst_addr=BFC00000; packets arrive at pcs BFC00000, BFC00004, BFC00008 with if_pc_plus4 correct.
- Hold stall=1 for 4 cycles in OUT with if_inst=0x24020001 -> all if_* stable and no inst_req; stall=0 -> next request at BFC00004.
- Assert branch (pc_branch=BFC00100) and jump (pc_jump=BFC00200) together in WAIT, then data_ok -> data discarded, if_valid stays 0, next inst_addr=BFC00100.
- Redirect while inst_req=1 with addr_ok low for 3 cycles -> inst_addr unchanged until accepted; one discarded fetch, then fetch from the redirect target.
- jump_reg to 0xBFC00102 -> no request issued; packet if_pc=BFC00102, if_adel=1, if_inst=0; exc to 0xBFC00380 in the same OUT cycle -> next inst_addr=BFC00380.
- reset=0 asynchronously mid-WAIT -> outputs return to reset values immediately; fetch restarts at RESET_PC.
